// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and instruction memory (slave).
// One read outstanding at most; imem_addr is held while imem_rd is high.
interface ifetch_unit_if #(
    parameter int unsigned PC_WIDTH = 10
);
    logic                imem_rd;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_data;
    logic                imem_ready;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_data,
        output imem_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, prefetches one instruction ahead into a single-entry buffer,
// applies branch/jump redirects and drops memory returns that a redirect made stale.
module ifetch_unit #(
    parameter int unsigned         PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_req_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr_o,
    output logic                instr_valid_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                busy_o,
    output logic                misaligned_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPrefetch,
        StDemand,
        StFull,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]         buf_q, buf_d;
    logic [31:0]         instr_q, instr_d;
    logic                pend_q, pend_d;
    logic                rd_q, rd_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                mis_q, mis_d;

    logic                read_out;
    logic                req_pend;
    logic                deliver;
    logic                new_read;
    logic [31:0]         deliver_data;

    assign read_out = (state_q == StPrefetch) || (state_q == StDemand) || (state_q == StDrain);
    // A request is owed to the FSM if one arrives now or an earlier one is still unserved.
    assign req_pend = busy_q || fetch_req_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        pend_d       = pend_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        mis_d        = mis_q;
        deliver      = 1'b0;
        deliver_data = imem.imem_data;

        if (redirect_i) begin
            pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            if (redirect_pc_i[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
            if (read_out && !imem.imem_ready) begin
                state_d = StDrain;
                pend_d  = req_pend;
            end else begin
                state_d = req_pend ? StDemand : StIdle;
                pend_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = fetch_req_i ? StDemand : StPrefetch;
                end
                StPrefetch: begin
                    if (imem.imem_ready) begin
                        if (fetch_req_i) begin
                            deliver = 1'b1;
                            state_d = StIdle;
                        end else begin
                            buf_d   = imem.imem_data;
                            state_d = StFull;
                        end
                    end else if (fetch_req_i) begin
                        state_d = StDemand;
                    end
                end
                StDemand: begin
                    if (imem.imem_ready) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end
                end
                StFull: begin
                    if (fetch_req_i) begin
                        deliver      = 1'b1;
                        deliver_data = buf_q;
                        state_d      = StIdle;
                    end
                end
                StDrain: begin
                    if (imem.imem_ready) begin
                        state_d = (pend_q || fetch_req_i) ? StDemand : StIdle;
                        pend_d  = 1'b0;
                    end else if (fetch_req_i) begin
                        pend_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (deliver) begin
            instr_d    = deliver_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + PC_WIDTH'(4);
        end

        rd_d     = (state_d == StPrefetch) || (state_d == StDemand) || (state_d == StDrain);
        // A fresh read starts only when nothing is outstanding or the current one completes now.
        new_read = rd_d && (!read_out || imem.imem_ready);
        if (new_read) begin
            addr_d = pc_d;
        end

        valid_d = deliver;
        busy_d  = (state_d == StDemand) || ((state_d == StDrain) && pend_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_pc_q <= '0;
            buf_q      <= '0;
            instr_q    <= '0;
            pend_q     <= 1'b0;
            rd_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_pc_q <= instr_pc_d;
            buf_q      <= buf_d;
            instr_q    <= instr_d;
            pend_q     <= pend_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            mis_q      <= mis_d;
        end
    end

    assign imem.imem_rd   = rd_q;
    assign imem.imem_addr = addr_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = valid_q;
    assign instr_pc_o     = instr_pc_q;
    assign pc_o           = pc_q;
    assign busy_o         = busy_q;
    assign misaligned_o   = mis_q;

endmodule
